sdram_user_initiator: RTL and testbench
=======================================

// Module: sdram_user_initiator
// PURPOSE
// Client-side initiator for the DDR_SDRAM_Controller user port (WrStart/WrReady, RdStart/RdReady, DevReady).
// Buffers posted writes in a small FIFO and accepts single read requests from the image pipeline.
// Arbitrates between the two and drives one controller command at a time.
// Returns read data to the requester and flags controller hangs with a timeout.
// PARAMETERS
// FIFO_DEPTH  8     write-buffer entries; power of 2, >=2
// WR_URGENT   6     FIFO level at or above which writes beat pending reads; <=FIFO_DEPTH
// TIMEOUT     1023  max cycles spent waiting for WrReady/RdReady before abort; 10-bit counter
// PORTS
// CLK_200MHz    in   1   system clock, all logic rising-edge
// RST_N         in   1   synchronous reset, active-low
// DevReady      in   1   controller init complete; no command issued while low
// wr_valid      in   1   write request present
// wr_ready      out  1   FIFO not full; push when wr_valid&wr_ready
// wr_bank       in   2   write bank
// wr_addr       in   23  write address
// wr_data       in   16  write data
// rd_req_valid  in   1   read request present (hold until rd_req_ready)
// rd_req_ready  out  1   1-cycle accept pulse for the read request
// rd_bank       in   2   read bank
// rd_addr       in   23  read address
// rd_resp_valid out  1   1-cycle pulse, rd_resp_data valid
// rd_resp_data  out  16  read data
// WrStart       out  1   1-cycle write command pulse to controller
// WrReady       in   1   controller write-idle
// WrBank        out  2   registered command bank
// WrAddr        out  23  registered command address
// WrData        out  16  registered command data
// RdStart       out  1   1-cycle read command pulse
// RdReady       in   1   controller read-idle / read done
// RdBank        out  2   registered command bank
// RdAddr        out  23  registered command address
// RdData        in   16  controller read data, valid when RdReady rises
// wr_level      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// busy          out  1   state != IDLE
// timeout_err   out  1   sticky; cleared only by reset
// BEHAVIOUR
// Reset (RST_N=0 at edge): state IDLE; FIFO emptied; wr_level=0.
//   All outputs 0 except wr_ready=1, incl. WrStart/RdStart, command fields, rd_resp_*, timeout_err.
//   Reset mid-command abandons it; no pulse completes afterwards.
// FIFO: push on wr_valid&wr_ready; pop only on write completion or write timeout.
//   Push and pop in same cycle -> level unchanged. Full -> wr_ready=0; pointers wrap modulo FIFO_DEPTH.
// Controller contract: WrReady/RdReady deassert on the cycle after the Start pulse is sampled.
//   The ready signal reasserts when the command is done.
// FSM states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
// IDLE: acts only when DevReady=1. Evaluate in this order:
//   (a) level>=WR_URGENT and WrReady=1 -> WR_ISSUE;
//   (b) rd_req_valid and RdReady=1 -> pulse rd_req_ready, latch rd_bank/rd_addr, -> RD_ISSUE;
//   (c) level>0 and WrReady=1 -> WR_ISSUE.
// WR_ISSUE: WrStart=1 for exactly 1 cycle; WrBank/WrAddr/WrData = FIFO head; clear timer; -> WR_WAIT.
// WR_WAIT: ignore the first cycle (ready still high). Then the first cycle with WrReady=1 pops the FIFO -> IDLE.
// RD_ISSUE: RdStart=1 for 1 cycle with latched bank/addr; clear timer; -> RD_WAIT.
// RD_WAIT: ignore the first cycle. Then on the first cycle with RdReady=1:
//   rd_resp_data<=RdData, rd_resp_valid=1 next cycle -> IDLE.
// Timer increments each WAIT cycle. Reaching TIMEOUT sets timeout_err, then -> IDLE:
//   write: head entry dropped (popped);
//   read: rd_resp_valid pulses with rd_resp_data=16'h0000.
// DevReady falling during WAIT does not abort; the timeout covers it.
// Command fields hold their last value between commands; only one command outstanding.
// Minimum write turnaround: 3 cycles (ISSUE, WAIT-skip, done).
// TESTING
// Reset: RST_N=0 for 2 cycles with wr_valid=1 -> wr_ready=1, wr_level=0, WrStart=RdStart=0, timeout_err=0.
// DevReady=0, push 3 writes (addr 0x10,0x11,0x12) -> no WrStart.
//   Raise DevReady -> 3 WrStart pulses in FIFO order; WrData matches; level 3->0.
// Fill FIFO to 8 with rd_req_valid held -> writes issue first until level<6, then read accepted.
//   Model returns RdData=0xC5A3 -> rd_resp_data=0xC5A3, single pulse.
// Push while popping at level 4 -> level stays 4. Push at level 8 -> wr_ready=0, entry not stored.
// Model never reasserts RdReady -> after 1023 wait cycles: timeout_err=1, rd_resp_valid with 0x0000.
//   A subsequent write still completes normally.
// Assert RST_N=0 during WR_WAIT -> next cycle busy=0, level=0, no pop or response pulse.

Source files
------------

// File: rtl/sdram_user_initiator.sv
// Client-side initiator for the DDR SDRAM controller user port: buffers posted
// writes, accepts single reads, issues one command at a time, flags hangs.
`timescale 1ns/1ps
module sdram_user_initiator #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WR_URGENT  = 6,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                        CLK_200MHz,
  input  logic                        RST_N,
  input  logic                        DevReady,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [1:0]                  wr_bank,
  input  logic [22:0]                 wr_addr,
  input  logic [15:0]                 wr_data,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [1:0]                  rd_bank,
  input  logic [22:0]                 rd_addr,
  output logic                        rd_resp_valid,
  output logic [15:0]                 rd_resp_data,
  output logic                        WrStart,
  input  logic                        WrReady,
  output logic [1:0]                  WrBank,
  output logic [22:0]                 WrAddr,
  output logic [15:0]                 WrData,
  output logic                        RdStart,
  input  logic                        RdReady,
  output logic [1:0]                  RdBank,
  output logic [22:0]                 RdAddr,
  input  logic [15:0]                 RdData,
  output logic [$clog2(FIFO_DEPTH):0] wr_level,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef logic [PW:0]   lvl_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [9:0]    tmr_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [22:0] addr;
    logic [15:0] data;
  } wr_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  localparam lvl_t FULL_LVL   = lvl_t'(FIFO_DEPTH);
  localparam lvl_t URGENT_LVL = lvl_t'(WR_URGENT);
  localparam tmr_t TMR_LAST   = tmr_t'(TIMEOUT - 1);

  state_t    state, state_nxt;
  wr_entry_t mem [FIFO_DEPTH];
  wr_entry_t head;
  ptr_t      wr_ptr, rd_ptr;
  tmr_t      timer;

  logic push, pop;
  logic wr_sel, rd_accept;
  logic timer_clr, timer_inc;
  logic set_tmo, resp_set, resp_zero;

  assign wr_ready     = (wr_level != FULL_LVL);
  assign push         = wr_valid & wr_ready;
  assign head         = mem[rd_ptr];
  assign busy         = (state != IDLE);
  assign WrStart      = (state == WR_ISSUE);
  assign RdStart      = (state == RD_ISSUE);
  assign rd_req_ready = rd_accept;

  // timer == 0 marks the first wait cycle, where the controller's ready is stale
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_sel    = 1'b0;
    rd_accept = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    set_tmo   = 1'b0;
    resp_set  = 1'b0;
    resp_zero = 1'b0;
    case (state)
      IDLE: begin
        if (DevReady) begin
          if ((wr_level >= URGENT_LVL) && WrReady) begin
            wr_sel    = 1'b1;
            state_nxt = WR_ISSUE;
          end else if (rd_req_valid && RdReady) begin
            rd_accept = 1'b1;
            state_nxt = RD_ISSUE;
          end else if ((wr_level != '0) && WrReady) begin
            wr_sel    = 1'b1;
            state_nxt = WR_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        timer_clr = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if ((timer != '0) && WrReady) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TMR_LAST) begin
          pop       = 1'b1;
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RD_ISSUE: begin
        timer_clr = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if ((timer != '0) && RdReady) begin
          resp_set  = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TMR_LAST) begin
          resp_set  = 1'b1;
          resp_zero = 1'b1;
          set_tmo   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_200MHz) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK_200MHz) begin
    if (!RST_N) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (timer_inc) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge CLK_200MHz) begin
    if (push) begin
      mem[wr_ptr] <= '{bank: wr_bank, addr: wr_addr, data: wr_data};
    end
  end

  always_ff @(posedge CLK_200MHz) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   wr_level <= wr_level + 1'b1;
        2'b01:   wr_level <= wr_level - 1'b1;
        default: wr_level <= wr_level;
      endcase
    end
  end

  // Command fields hold between commands; the FIFO head stays put until pop
  always_ff @(posedge CLK_200MHz) begin
    if (!RST_N) begin
      WrBank <= '0;
      WrAddr <= '0;
      WrData <= '0;
      RdBank <= '0;
      RdAddr <= '0;
    end else begin
      if (wr_sel) begin
        WrBank <= head.bank;
        WrAddr <= head.addr;
        WrData <= head.data;
      end
      if (rd_accept) begin
        RdBank <= rd_bank;
        RdAddr <= rd_addr;
      end
    end
  end

  always_ff @(posedge CLK_200MHz) begin
    if (!RST_N) begin
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
      timeout_err   <= 1'b0;
    end else begin
      rd_resp_valid <= resp_set;
      if (resp_set) begin
        rd_resp_data <= resp_zero ? '0 : RdData;
      end
      if (set_tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_user_initiator.sv
// Scoreboard bench for sdram_user_initiator with a behavioural controller model.
`timescale 1ns/1ps
module tb_sdram_user_initiator;

  logic        clk = 1'b0;
  logic        RST_N, DevReady;
  logic        wr_valid, wr_ready;
  logic [1:0]  wr_bank;
  logic [22:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req_valid, rd_req_ready;
  logic [1:0]  rd_bank;
  logic [22:0] rd_addr;
  logic        rd_resp_valid;
  logic [15:0] rd_resp_data;
  logic        WrStart, WrReady;
  logic [1:0]  WrBank;
  logic [22:0] WrAddr;
  logic [15:0] WrData;
  logic        RdStart, RdReady;
  logic [1:0]  RdBank;
  logic [22:0] RdAddr;
  logic [15:0] RdData;
  logic [3:0]  wr_level;
  logic        busy, timeout_err;

  int total = 0;
  int bad = 0;
  int wr_starts = 0;

  logic [40:0] wr_q[$];
  logic [24:0] rd_cmd_q[$];
  logic [15:0] rd_resp_q[$];

  logic        rd_hang = 1'b0;
  logic [15:0] rd_model_data = 16'h0000;
  logic        wpend = 1'b0, rpend = 1'b0;
  int          wcnt = 0, rcnt = 0;

  always #5 clk = ~clk;

  sdram_user_initiator #(
    .FIFO_DEPTH(8),
    .WR_URGENT (6),
    .TIMEOUT   (1023)
  ) dut (
    .CLK_200MHz   (clk),
    .RST_N        (RST_N),
    .DevReady     (DevReady),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_bank      (rd_bank),
    .rd_addr      (rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .WrStart      (WrStart),
    .WrReady      (WrReady),
    .WrBank       (WrBank),
    .WrAddr       (WrAddr),
    .WrData       (WrData),
    .RdStart      (RdStart),
    .RdReady      (RdReady),
    .RdBank       (RdBank),
    .RdAddr       (RdAddr),
    .RdData       (RdData),
    .wr_level     (wr_level),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected pulse required none", name);
  endtask

  // Controller model: ready drops the cycle after Start is seen, returns later.
  initial begin
    WrReady = 1'b1;
    RdReady = 1'b1;
    RdData  = 16'h0000;
    forever begin
      @(negedge clk);
      if (WrStart) begin
        wpend = 1'b1;
      end else if (wpend) begin
        WrReady = 1'b0;
        wcnt    = 2;
        wpend   = 1'b0;
      end else if (!WrReady) begin
        if (wcnt > 0) wcnt--;
        if (wcnt == 0) WrReady = 1'b1;
      end
      if (RdStart) begin
        rpend = 1'b1;
      end else if (rpend) begin
        RdReady = 1'b0;
        rcnt    = 3;
        rpend   = 1'b0;
      end else if (!RdReady) begin
        if (rcnt > 0) rcnt--;
        if (rcnt == 0 && !rd_hang) begin
          RdData  = rd_model_data;
          RdReady = 1'b1;
        end
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a command or response
  initial begin
    forever begin
      @(negedge clk);
      if (WrStart) begin
        wr_starts++;
        if (wr_q.size() == 0) unexpected("wr_cmd");
        else check("wr_cmd", 64'({WrBank, WrAddr, WrData}), 64'(wr_q.pop_front()));
      end
      if (RdStart) begin
        if (rd_cmd_q.size() == 0) unexpected("rd_cmd");
        else check("rd_cmd", 64'({RdBank, RdAddr}), 64'(rd_cmd_q.pop_front()));
      end
      if (rd_resp_valid) begin
        if (rd_resp_q.size() == 0) unexpected("rd_resp");
        else check("rd_resp", 64'(rd_resp_data), 64'(rd_resp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [1:0] b, input logic [22:0] a, input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_bank  = b;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 100; i++) begin
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("push_ready", ok, 1'b1);
    wr_q.push_back({b, a, d});
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic rd_request(input logic [1:0] b, input logic [22:0] a, input logic [15:0] resp,
                            output int lvl, output int starts);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_bank      = b;
    rd_addr      = a;
    rd_cmd_q.push_back({b, a});
    rd_resp_q.push_back(resp);
    for (int i = 0; i < 200; i++) begin
      #1;
      if (rd_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lvl    = int'(wr_level);
    starts = wr_starts;
    check("rd_accept_seen", ok, 1'b1);
    @(posedge clk);
    #1 rd_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && wr_level == 0 && !rd_resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  initial begin
    #600000;
    total++;
    bad++;
    $display("FAIL watchdog: got no completion required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lvl, starts, base, n;
    logic found, prev;

    RST_N = 1'b0; DevReady = 1'b0; wr_valid = 1'b1;
    wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_bank = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_level", wr_level, 0);
    check("rst_wrstart", WrStart, 1'b0);
    check("rst_rdstart", RdStart, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", rd_resp_valid, 1'b0);
    wr_valid = 1'b0;
    RST_N    = 1'b1;

    // Writes held off while the controller is not ready
    push(2'd0, 23'h10, 16'hA000);
    push(2'd1, 23'h11, 16'hA001);
    push(2'd2, 23'h12, 16'hA002);
    repeat (10) @(negedge clk);
    check("devready_low_no_start", wr_starts, 0);
    check("devready_low_level", wr_level, 3);
    DevReady = 1'b1;
    wait_idle(100, "drain3_done");
    check("drain3_starts", wr_starts, 3);

    // Fill to full, reject overflow, then urgent writes beat the read
    @(negedge clk);
    DevReady = 1'b0;
    for (int i = 0; i < 8; i++) push(2'(i), 23'h100 + 23'(i), 16'h1000 + 16'(i));
    @(negedge clk);
    check("full_level", wr_level, 8);
    check("full_wr_ready", wr_ready, 1'b0);
    wr_valid = 1'b1; wr_bank = 2'd3; wr_addr = 23'h7FFFFF; wr_data = 16'hBEEF;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("full_push_rejected", wr_level, 8);
    base          = wr_starts;
    rd_model_data = 16'hC5A3;
    DevReady      = 1'b1;
    rd_request(2'd2, 23'h45678, 16'hC5A3, lvl, starts);
    check("rd_accept_level", lvl, 5);
    check("writes_before_read", starts - base, 3);
    wait_idle(300, "prio_drain_done");
    check("prio_total_writes", wr_starts - base, 8);

    // Push in the same cycle as a pop
    @(negedge clk);
    DevReady = 1'b0;
    for (int i = 0; i < 4; i++) push(2'(i), 23'h200 + 23'(i), 16'h2000 + 16'(i));
    @(negedge clk);
    check("pp_level_before", wr_level, 4);
    DevReady = 1'b1;
    prev  = WrReady;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!prev && WrReady) begin
        found = 1'b1;
        break;
      end
      prev = WrReady;
    end
    check("pp_pop_edge_seen", found, 1'b1);
    wr_valid = 1'b1; wr_bank = 2'd3; wr_addr = 23'h2FF; wr_data = 16'h5555;
    wr_q.push_back({2'd3, 23'h2FF, 16'h5555});
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("pp_level_same", wr_level, 4);
    wait_idle(200, "pp_drain_done");

    // Reset during WR_WAIT abandons the command
    push(2'd1, 23'h300, 16'h7777);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (WrStart) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_start_seen", found, 1'b1);
    base = wr_starts;
    @(negedge clk);
    RST_N = 1'b0;
    @(negedge clk);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_level", wr_level, 0);
    check("rstmid_resp", rd_resp_valid, 1'b0);
    RST_N = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_no_reissue", wr_starts - base, 0);
    check("rstmid_level_after", wr_level, 0);

    // Plain read with a different data pattern
    rd_model_data = 16'h5A5A;
    rd_request(2'd1, 23'h70001, 16'h5A5A, lvl, starts);
    wait_idle(50, "read2_done");
    check("pre_timeout_err", timeout_err, 1'b0);

    // Hung read: timeout after 1023 wait cycles, zero data returned
    rd_hang = 1'b1;
    rd_request(2'd3, 23'h1ABCD, 16'h0000, lvl, starts);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (RdStart) begin
        found = 1'b1;
        break;
      end
    end
    check("tmo_rdstart_seen", found, 1'b1);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      n++;
      if (rd_resp_valid) break;
    end
    check("tmo_cycles", n, 1024);
    @(negedge clk);
    check("tmo_err_set", timeout_err, 1'b1);
    rd_hang = 1'b0;
    repeat (3) @(negedge clk);

    base = wr_starts;
    push(2'd2, 23'h400, 16'h9999);
    wait_idle(50, "post_tmo_write_done");
    check("post_tmo_write", wr_starts - base, 1);
    check("tmo_err_sticky", timeout_err, 1'b1);

    repeat (5) @(negedge clk);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_cmd_q_empty", rd_cmd_q.size(), 0);
    check("rd_resp_q_empty", rd_resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
